program_rom_sequencer: RTL
==========================

// Module: program_rom_sequencer
// PURPOSE
//  Parametrised program ROM with a built-in sequencer. Holds PROG_LEN packed
//  operand words {d,c,b,a} and streams them out in address order over a
//  valid/ready handshake. Each word is unpacked into its four operands and
//  W = (a+d)*b - c is computed. Sits between the program store and the datapath.
// PARAMETERS
//  OPW       4                  operand width; word width WORD_W = 4*OPW
//  DEPTH     16                 ROM depth in words; AW = $clog2(DEPTH)
//  PROG_LEN  4                  words in program, 1..DEPTH (elaboration assert)
//  PROGRAM   {..,16'h7757,16'h1256,16'h2138,16'h1234}  DEPTH*WORD_W packed, entry i at [i*WORD_W +: WORD_W]
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           synchronous, active-high reset
//  start      in   1           begin a run at address 0 (sampled in IDLE only)
//  loop_en    in   1           1: wrap to address 0 after last word, never finish
//  stop       in   1           synchronous abort of a run
//  out_ready  in   1           consumer accepts out_word this cycle
//  out_valid  out  1           out_word/out_* hold a valid word
//  out_word   out  WORD_W      raw ROM word
//  out_addr   out  AW          address of out_word
//  out_a..d   out  OPW each    a=[OPW-1:0], b=[2OPW-1:OPW], c=[3OPW-1:2OPW], d=top
//  out_res    out  2*OPW+2     signed (a+d)*b - c, operands zero-extended
//  busy       out  1           1 in FETCH or HOLD
//  done       out  1           one-cycle pulse: run completed (loop_en=0)
// BEHAVIOUR
//  Reset: state IDLE; out_valid, out_word, out_addr, busy, done = 0.
//  FSM IDLE -> FETCH -> HOLD -> DONE -> IDLE.
//   IDLE : start=1 -> addr=0, FETCH. start in any other state is ignored.
//   FETCH: one cycle. Register ROM[addr] into out_word; out_valid=1 next cycle; -> HOLD.
//   HOLD : out_valid=1. out_word/out_addr stable while out_ready=0.
//          Handshake (out_valid & out_ready) when addr < PROG_LEN-1: load
//          ROM[addr+1] in the same edge; stay in HOLD (1 word/cycle, no bubble).
//          Handshake at addr == PROG_LEN-1: loop_en=1 loads ROM[0], addr=0,
//          stays in HOLD; loop_en=0 clears out_valid and goes to DONE.
//   DONE : done=1 for exactly one cycle; -> IDLE.
//  Latency: start at edge N -> out_valid=1 after edge N+2.
//  loop_en is sampled only at the last-word handshake.
//  stop=1 in FETCH/HOLD: out_valid=0 next cycle, go to IDLE, no done pulse.
//   stop beats a same-cycle handshake; the word counts as not consumed.
//  PROGRAM entries at addresses >= PROG_LEN are never read.
//  out_res is combinational from out_word and valid only with out_valid.
//   Range is -(2^OPW-1) .. (2^(OPW+1)-2)*(2^OPW-1), so 2*OPW+2 bits signed.
//  rst mid-run: return to reset values on that edge; no done pulse.
// TESTING
//  1 rst, start pulse, out_ready=1 -> words 1234,2138,1256,7757 on 4 consecutive
//    cycles, out_res 13,29,33,63, addr 0..3, done pulse the cycle after 7757.
//  2 out_ready=0 for 3 cycles at addr 1 -> out_word=2138 held stable; then
//    resume with no word skipped or repeated.
//  3 loop_en=1 -> 7757 followed directly by 1234 (addr 0), no done; stop
//    mid-HOLD -> out_valid=0 next cycle, state IDLE, no done.
//  4 start pulses while busy -> ignored, sequence unchanged; rst at addr 2
//    -> all outputs 0 next cycle; a new start restarts at addr 0.
//  5 OPW=8, DEPTH=8, PROG_LEN=8, one word with a=0, d=0, b=0, c=5
//    -> out_res = -5. Word {d,c,b,a}={FF,00,FF,FF} -> 130050.
//    Loop wraps 7 -> 0.

Source files
------------

// File: rtl/program_rom_sequencer_if.sv
// Output stream of the program ROM sequencer: one ROM word per valid/ready handshake.
// out_res is a two's-complement value; consumers read it with $signed().
interface program_rom_sequencer_if #(
    parameter int unsigned OPW = 4,
    parameter int unsigned AW  = 4
);
    localparam int unsigned WORD_W = 4 * OPW;
    localparam int unsigned RES_W  = 2 * OPW + 2;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [AW-1:0]     out_addr;
    logic [OPW-1:0]    out_a;
    logic [OPW-1:0]    out_b;
    logic [OPW-1:0]    out_c;
    logic [OPW-1:0]    out_d;
    logic [RES_W-1:0]  out_res;

    modport master (
        output out_valid, out_word, out_addr, out_a, out_b, out_c, out_d, out_res,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_word, out_addr, out_a, out_b, out_c, out_d, out_res,
        output out_ready
    );
endinterface

// File: rtl/program_rom_sequencer.sv
// Program ROM with a sequencer that streams PROG_LEN words in address order and
// unpacks each word {d,c,b,a} into operands plus W = (a+d)*b - c.
module program_rom_sequencer #(
    parameter int unsigned OPW      = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PROG_LEN = 4,
    parameter logic [DEPTH*4*OPW-1:0] PROGRAM =
        (DEPTH*4*OPW)'(64'h7757_1256_2138_1234)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_loop_en,
    input  logic i_stop,
    output logic o_busy,
    output logic o_done,
    program_rom_sequencer_if.master bus
);
    localparam int unsigned WORD_W = 4 * OPW;
    localparam int unsigned RES_W  = 2 * OPW + 2;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PROG_LEN - 1);

    if (PROG_LEN < 1 || PROG_LEN > DEPTH) begin : g_bad_prog_len
        $error("program_rom_sequencer: PROG_LEN must be in 1..DEPTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     w_addr_nxt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_nxt;
    logic              w_load;
    logic              r_busy;
    logic              r_done;
    logic              w_handshake;
    logic [OPW-1:0]    w_a;
    logic [OPW-1:0]    w_b;
    logic [OPW-1:0]    w_c;
    logic [OPW-1:0]    w_d;
    logic [RES_W-1:0]  w_res;
    logic [WORD_W-1:0] w_rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign w_rom[gi] = PROGRAM[gi*WORD_W +: WORD_W];
    end

    assign w_handshake = r_valid & bus.out_ready;

    // Next state; stop wins over a same-cycle handshake so that word is not consumed
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_stop) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_stop) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_handshake) begin
                    if (r_addr < LAST_ADDR) begin
                        w_addr_nxt = r_addr + AW'(1);
                        w_load     = 1'b1;
                    end else if (i_loop_en) begin
                        w_addr_nxt = '0;
                        w_load     = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_word_nxt = w_load ? w_rom[w_addr_nxt] : r_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_word  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_word  <= w_word_nxt;
            r_busy  <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_HOLD);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Operands zero-extended; modular arithmetic in RES_W bits yields the signed result
    assign w_a   = r_word[OPW-1:0];
    assign w_b   = r_word[2*OPW-1:OPW];
    assign w_c   = r_word[3*OPW-1:2*OPW];
    assign w_d   = r_word[4*OPW-1:3*OPW];
    assign w_res = (RES_W'(w_a) + RES_W'(w_d)) * RES_W'(w_b) - RES_W'(w_c);

    assign bus.out_valid = r_valid;
    assign bus.out_word  = r_word;
    assign bus.out_addr  = r_addr;
    assign bus.out_a     = w_a;
    assign bus.out_b     = w_b;
    assign bus.out_c     = w_c;
    assign bus.out_d     = w_d;
    assign bus.out_res   = w_res;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
endmodule
